// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, typedefs and constants for the multi-port register file.
//   XLEN_DEFAULT / NREGS_DEFAULT : default word width and register count
//   reg_addr_t / reg_word_t      : address and word types at the default configuration
//   ZERO_REG                     : index of the hardwired-zero register
package regfile_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned AW_DEFAULT    = $clog2(NREGS_DEFAULT);
    localparam int unsigned ZERO_REG      = 0;

    typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] reg_word_t;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits plus a running count of set bits.
//   clk, reset          : clock, synchronous active-high reset
//   rsv_en, rsv_addr    : mark a register pending (issue)
//   wr_en, wr_addr      : clear a register's pending bit (write-back)
//   busy                : current pending bits (bit 0 is never set)
//   busy_cnt            : registered number of set pending bits
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_cnt
);

    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_cnt;

    logic w_set;
    logic w_clr;
    logic w_inc;
    logic w_dec;

    assign w_set = rsv_en && (rsv_addr != AW'(ZERO_REG));
    assign w_clr = wr_en  && (wr_addr  != AW'(ZERO_REG));

    // Count moves only on real 0->1 / 1->0 transitions; a same-address set beats the clear.
    assign w_inc = w_set && !r_busy[rsv_addr];
    assign w_dec = w_clr && r_busy[wr_addr] && !(w_set && (rsv_addr == wr_addr));

    // Pending bits and count; the set is applied last so it wins on a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_clr) begin
                r_busy[wr_addr] <= 1'b0;
            end
            if (w_set) begin
                r_busy[rsv_addr] <= 1'b1;
            end
            r_cnt <= r_cnt + (AW+1)'(w_inc) - (AW+1)'(w_dec);
        end
    end

    assign busy     = r_busy;
    assign busy_cnt = r_cnt;

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with a pending-write scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (same-edge write-to-read forwarding,
// and rs_busy hides a register being written back this cycle).
//   clk, reset          : clock, synchronous active-high reset
//   rd_en, rs_addr      : read strobe and NRD packed read addresses
//   rs_data             : registered read data, NRD packed words
//   rs_busy             : combinational pending flag per read address
//   wr_en, wr_addr/data : write-back port
//   rsv_en, rsv_addr    : destination reservation
//   busy_cnt            : registered count of pending registers
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned NRD   = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [NRD*AW-1:0] rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]    rs_busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    output logic [AW:0]       busy_cnt
);

    logic [XLEN-1:0]     r_regs [NREGS];
    logic [NRD*XLEN-1:0] r_rs_data;

    logic [NREGS-1:0]    w_busy;
    logic [NRD*XLEN-1:0] w_rd_data;
    logic                w_wr;

    assign w_wr = wr_en && (wr_addr != AW'(ZERO_REG));

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy     (w_busy),
        .busy_cnt (busy_cnt)
    );

    // Read-port mux; register 0 is forced to zero rather than stored.
    always_comb begin
        logic [AW-1:0] w_a;
        w_rd_data = '0;
        w_a       = '0;
        for (int i = 0; i < NRD; i++) begin
            w_a = rs_addr[i*AW +: AW];
            if (w_a != AW'(ZERO_REG)) begin
                w_rd_data[i*XLEN +: XLEN] = r_regs[w_a];
`ifdef REGFILE_BYPASS_EN
                if (w_wr && (wr_addr == w_a)) begin
                    w_rd_data[i*XLEN +: XLEN] = wr_data;
                end
`endif
            end
        end
    end

    // Pending flag per read port, looked up from the scoreboard's current bits.
    always_comb begin
        logic [AW-1:0] w_b;
        rs_busy = '0;
        w_b     = '0;
        for (int i = 0; i < NRD; i++) begin
            w_b = rs_addr[i*AW +: AW];
            rs_busy[i] = (w_b != AW'(ZERO_REG)) && w_busy[w_b];
`ifdef REGFILE_BYPASS_EN
            // A write-back landing this cycle resolves the hazard unless re-reserved.
            if (wr_en && (wr_addr == w_b) && !(rsv_en && (rsv_addr == w_b))) begin
                rs_busy[i] = 1'b0;
            end
`endif
        end
    end

    // Storage and registered read data; reset overrides any same-cycle write or read.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
            r_rs_data <= '0;
        end else begin
            if (w_wr) begin
                r_regs[wr_addr] <= wr_data;
            end
            if (rd_en) begin
                r_rs_data <= w_rd_data;
            end
        end
    end

    assign rs_data = r_rs_data;

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed plus random stimulus against an array-based reference model;
// expected read data is queued at issue and popped by an independent monitor.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned AW    = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 rd_en;
    logic [NRD*AW-1:0]    rs_addr;
    logic [NRD*XLEN-1:0]  rs_data;
    logic [NRD-1:0]       rs_busy;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [XLEN-1:0]      wr_data;
    logic                 rsv_en;
    logic [AW-1:0]        rsv_addr;
    logic [AW:0]          busy_cnt;

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (rd_en),
        .rs_addr  (rs_addr),
        .rs_data  (rs_data),
        .rs_busy  (rs_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_cnt (busy_cnt)
    );

    // Reference model state
    reg_word_t m_regs [NREGS];
    bit        m_busy [NREGS];
    int        exp_cnt = 0;
    logic [NRD*XLEN-1:0] exp_q [$];
    bit        mon_en = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_cnt();
        int c = 0;
        for (int r = 0; r < NREGS; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    function automatic reg_word_t model_read(input reg_addr_t a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic model_rs_busy(input reg_addr_t a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a && !(rsv_en && rsv_addr == a)) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    task automatic drive(input bit rd, input int a0, input int a1,
                         input bit wr, input int wa, input logic [31:0] wd,
                         input bit rsv, input int ra, input bit rst);
        rd_en    = rd;
        rs_addr  = {AW'(a1), AW'(a0)};
        wr_en    = wr;
        wr_addr  = AW'(wa);
        wr_data  = wd;
        rsv_en   = rsv;
        rsv_addr = AW'(ra);
        reset    = rst;
    endtask

    // One clock: check combinational busy flags, then advance model at the edge.
    task automatic step();
        logic [NRD*XLEN-1:0] e;
        #2;
        if (mon_en) begin
            for (int i = 0; i < NRD; i++)
                chk($sformatf("rs_busy[%0d]", i), 64'(rs_busy[i]),
                    64'(model_rs_busy(rs_addr[i*AW +: AW])));
        end
        @(posedge clk);
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
            exp_q.push_back('0);
            mon_en = 1'b1;
        end else begin
            if (rd_en) begin
                e = '0;
                for (int i = 0; i < NRD; i++)
                    e[i*XLEN +: XLEN] = model_read(rs_addr[i*AW +: AW]);
                exp_q.push_back(e);
            end
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        end
        exp_cnt = model_cnt();
        @(negedge clk);
    endtask

    // Monitor: one queued read response per registered update, plus the count every cycle.
    always @(negedge clk) begin
        logic [NRD*XLEN-1:0] got;
        if (mon_en) begin
            chk("busy_cnt", 64'(busy_cnt), 64'(exp_cnt));
            if (exp_q.size() > 0) begin
                got = exp_q.pop_front();
                for (int i = 0; i < NRD; i++)
                    chk($sformatf("rs_data[%0d]", i), 64'(rs_data[i*XLEN +: XLEN]),
                        64'(got[i*XLEN +: XLEN]));
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0, 1);
        step();
        step();

        // Reset state: every register reads zero, nothing pending.
        for (int k = 0; k < 16; k++) begin
            drive(1, 2*k, 2*k+1, 0, 0, 32'h0, 0, 0, 0);
            step();
        end
        chk("reset_cnt", 64'(busy_cnt), 64'd0);

        // Write then read back one cycle later.
        drive(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        step();
        drive(1, 5, 0, 0, 0, 32'h0, 0, 0, 0);
        step();
        chk("r5_read", 64'(rs_data[31:0]), 64'hDEADBEEF);

        // Register 0 ignores writes and reservations.
        drive(0, 0, 0, 1, 0, 32'h12345678, 1, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        step();
        chk("r0_read", 64'(rs_data[31:0]), 64'h0);
        chk("r0_cnt", 64'(busy_cnt), 64'd0);

        // Same-edge write and read of one address.
        drive(0, 0, 0, 1, 7, 32'h1, 0, 0, 0);
        step();
        drive(1, 7, 0, 1, 7, 32'hA5A5A5A5, 0, 0, 0);
        step();
`ifdef REGFILE_BYPASS_EN
        chk("r7_same_edge", 64'(rs_data[31:0]), 64'hA5A5A5A5);
`else
        chk("r7_same_edge", 64'(rs_data[31:0]), 64'h1);
`endif

        // Reservation counting, double reserve, set-beats-clear, clear.
        drive(0, 0, 0, 0, 0, 32'h0, 1, 3, 0); step();
        drive(0, 0, 0, 0, 0, 32'h0, 1, 3, 0); step();
        drive(0, 0, 0, 0, 0, 32'h0, 1, 4, 0); step();
        chk("cnt_two", 64'(busy_cnt), 64'd2);
        drive(0, 3, 4, 1, 3, 32'h33, 1, 3, 0); step();
        chk("cnt_collide", 64'(busy_cnt), 64'd2);
        chk("r3_still_busy", 64'(rs_busy[0]), 64'd1);
        drive(0, 3, 4, 1, 4, 32'h44, 0, 0, 0); step();
        chk("cnt_one", 64'(busy_cnt), 64'd1);

        // Reset mid-sequence discards reservations and the concurrent write.
        drive(0, 0, 0, 0, 0, 32'h0, 1, 9, 0); step();
        drive(0, 0, 0, 0, 0, 32'h0, 1, 10, 0); step();
        drive(0, 0, 0, 1, 9, 32'hCAFEF00D, 0, 0, 1); step();
        drive(1, 9, 10, 0, 0, 32'h0, 0, 0, 0); step();
        chk("rst_cnt", 64'(busy_cnt), 64'd0);
        chk("rst_r9", 64'(rs_data[31:0]), 64'h0);

        // Random traffic with frequent address collisions and occasional reset.
        for (int n = 0; n < 600; n++) begin
            int wa, ra, a0, a1;
            wa = int'($urandom_range(0, 31));
            ra = ($urandom % 4 == 0) ? wa : int'($urandom_range(0, 31));
            a0 = ($urandom % 3 == 0) ? wa : int'($urandom_range(0, 31));
            a1 = ($urandom % 3 == 0) ? ra : int'($urandom_range(0, 31));
            drive($urandom % 4 != 0, a0, a1, $urandom % 2 == 0, wa, $urandom,
                  $urandom % 5 < 2, ra, $urandom % 80 == 0);
            step();
        end

        drive(0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        step();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, >=4); AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rd_en  input  1  read strobe; samples all read ports.
REQ-007 SHALL have port rs_addr  input  NRD*AW  read addresses; port i at bits [i*AW +: AW].
REQ-008 SHALL have port rs_data  output  NRD*XLEN  registered read data; port i at [i*XLEN +: XLEN].
REQ-009 SHALL have port rs_busy  output  NRD  combinational; pending-write flag for each rs_addr.
REQ-010 SHALL have port wr_en  input  1  write strobe (write-back).
REQ-011 SHALL have port wr_addr  input  AW  write destination.
REQ-012 SHALL have port wr_data  input  XLEN  write data.
REQ-013 SHALL have port rsv_en  input  1  reserve destination (issue marks register pending).
REQ-014 SHALL have port rsv_addr  input  AW  register to reserve.
REQ-015 SHALL have port busy_cnt  output  AW+1  registered count of pending registers.

Function
REQ-016 Register 0 SHALL always read 0, ignore writes and reservations, never report busy.
REQ-017 On a rising edge with rd_en=1, rs_data[i] SHALL load the value of register rs_addr[i]; latency 1 cycle.
REQ-018 With rd_en=0, rs_data SHALL hold its previous value.
REQ-019 On a rising edge with wr_en=1 and wr_addr!=0, register wr_addr SHALL take wr_data.
REQ-020 Same-edge read and write of one address: read behaviour per REQ-031/REQ-032.
REQ-021 Scoreboard: one busy bit per register; rsv_en=1 with rsv_addr!=0 SHALL set busy[rsv_addr] at the edge.
REQ-022 wr_en=1 SHALL clear busy[wr_addr] at the edge; clearing a non-busy bit is legal and a no-op.
REQ-023 rsv_en and wr_en on the same nonzero address in one cycle: set SHALL win (busy stays 1, data still written).
REQ-024 Reserving an already-busy register SHALL leave the bit at 1 and busy_cnt unchanged.
REQ-025 busy_cnt SHALL equal the number of set busy bits after each edge: +1 per 0->1, -1 per 1->0, unchanged when both or neither occur.
REQ-026 busy_cnt SHALL never wrap; max value NREGS-1.
REQ-027 rs_busy[i] SHALL equal busy[rs_addr[i]] from current state (0 for address 0).

Reset
REQ-028 While reset=1 at an edge, all registers, rs_data, busy bits and busy_cnt SHALL become 0.
REQ-029 Reset SHALL take priority over rd_en, wr_en and rsv_en in the same cycle.
REQ-030 Reset asserted mid-sequence SHALL discard all pending reservations; no write completes in that cycle.

Configuration
REQ-031 With macro REGFILE_BYPASS_EN defined: same-edge read of wr_addr (nonzero, wr_en=1) SHALL return wr_data; rs_busy[i] SHALL read 0 when wr_en=1, wr_addr==rs_addr[i] and no same-address rsv_en.
REQ-032 Without REGFILE_BYPASS_EN: same-edge read SHALL return the old register value; rs_busy reflects pre-edge state only.

Structure
REQ-033 Package regfile_pkg SHALL hold XLEN default, address/word typedefs (reg_addr_t, reg_word_t) and the zero-register constant.
REQ-034 The scoreboard (busy bits + busy_cnt) SHALL be sub-module regfile_scoreboard, instantiated once.

Verification
REQ-035 Reset, then read r0..r31 -> all rs_data 0, busy_cnt 0, rs_busy 0.
REQ-036 Write r5=0xDEADBEEF, next cycle read rs_addr0=5 -> rs_data0=0xDEADBEEF one cycle after rd_en.
REQ-037 Write r0=0x12345678 and rsv r0 -> read r0 gives 0, busy_cnt stays 0.
REQ-038 Same cycle wr r7=0xA5A5A5A5 and read r7 (old 0x1) -> 0xA5A5A5A5 with REGFILE_BYPASS_EN, 0x1 without.
REQ-039 rsv r3, rsv r3 again, rsv r4 -> busy_cnt 2; wr r3 with rsv r3 same cycle -> busy stays 1, cnt 2; wr r4 -> cnt 1.
REQ-040 rsv r9, r10 then reset mid-sequence with wr_en=1 to r9 -> busy_cnt 0, r9 reads 0.
